// File: rtl/muldiv_seq.sv
// Iterative multiply / multiply-accumulate / unsigned and signed divide unit.
// Each operation takes WIDTH iterations plus one cycle of result formation before done pulses.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] SrcAcc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MLA  = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FIN = 2'b10, DONE = 2'b11} state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // 0x80..0 maps to itself, which the unsigned loop then treats as 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;       // multiplicand (shifted) or dividend/quotient
  logic [WIDTH-1:0] b_r;       // multiplier (shifted) or divisor
  logic [WIDTH-1:0] acc_r;     // product or partial remainder
  logic [WIDTH-1:0] addend_r;
  logic [WIDTH-1:0] srca_r;
  logic             qneg_r;
  logic             aneg_r;

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] a_nx_s;
  logic [WIDTH-1:0] b_nx_s;
  logic [WIDTH-1:0] acc_nx_s;
  logic [WIDTH-1:0] fin_res_s;
  logic [WIDTH-1:0] fin_rem_s;
  logic             fin_dz_s;

  // One shift-add or restoring-divide step.
  always_comb begin
    rem_sh_s = {acc_r, a_r[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, b_r};
    a_nx_s   = a_r;
    b_nx_s   = b_r;
    acc_nx_s = acc_r;
    if (op_r[1]) begin
      a_nx_s = {a_r[WIDTH-2:0], ~diff_s[WIDTH]};
      if (diff_s[WIDTH]) begin
        acc_nx_s = rem_sh_s[WIDTH-1:0];
      end else begin
        acc_nx_s = diff_s[WIDTH-1:0];
      end
    end else begin
      a_nx_s = a_r << 1;
      b_nx_s = b_r >> 1;
      if (b_r[0]) begin
        acc_nx_s = acc_r + a_r;
      end else begin
        acc_nx_s = acc_r;
      end
    end
  end

  // Final result formation, applied in FIN.
  always_comb begin
    fin_res_s = {WIDTH{1'b0}};
    fin_rem_s = {WIDTH{1'b0}};
    fin_dz_s  = 1'b0;
    case (op_r)
      OP_MUL: fin_res_s = acc_r;
      OP_MLA: fin_res_s = acc_r + addend_r;
      OP_UDIV, OP_SDIV: begin
        if (b_r == {WIDTH{1'b0}}) begin
          fin_rem_s = srca_r;
          fin_dz_s  = 1'b1;
        end else if (op_r == OP_SDIV) begin
          fin_res_s = qneg_r ? negate(a_r) : a_r;
          fin_rem_s = aneg_r ? negate(acc_r) : acc_r;
        end else begin
          fin_res_s = a_r;
          fin_rem_s = acc_r;
        end
      end
      default: fin_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= {CNTW{1'b0}};
      op_r      <= 2'b00;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      addend_r  <= {WIDTH{1'b0}};
      srca_r    <= {WIDTH{1'b0}};
      qneg_r    <= 1'b0;
      aneg_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Result    <= {WIDTH{1'b0}};
      Remainder <= {WIDTH{1'b0}};
      DivZero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_r     <= op;
            srca_r   <= SrcA;
            addend_r <= SrcAcc;
            acc_r    <= {WIDTH{1'b0}};
            cnt      <= CNTW'(WIDTH - 1);
            if (op == OP_SDIV) begin
              a_r    <= magnitude(SrcA);
              b_r    <= magnitude(SrcB);
              qneg_r <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
              aneg_r <= SrcA[WIDTH-1];
            end else begin
              a_r    <= SrcA;
              b_r    <= SrcB;
              qneg_r <= 1'b0;
              aneg_r <= 1'b0;
            end
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          a_r   <= a_nx_s;
          b_r   <= b_nx_s;
          acc_r <= acc_nx_s;
          cnt   <= cnt - CNTW'(1);
          if (cnt == {CNTW{1'b0}}) begin
            state <= FIN;
          end else begin
            state <= RUN;
          end
          busy <= 1'b1;
          done <= 1'b0;
        end
        FIN: begin
          Result    <= fin_res_s;
          Remainder <= fin_rem_s;
          DivZero   <= fin_dz_s;
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, multi-cycle corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] SrcA, SrcB, SrcAcc;
  logic        busy, done, DivZero;
  logic [31:0] Result, Remainder;

  int vectors = 0;
  int miscompares = 0;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .SrcA(SrcA), .SrcB(SrcB), .SrcAcc(SrcAcc),
    .busy(busy), .done(done), .Result(Result),
    .Remainder(Remainder), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, acc;
    logic [31:0] res, rem;
    logic        dz;
  } vec_t;

  vec_t tbl [0:11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic with the divide-by-zero and overflow rules.
  task automatic model(input logic [1:0] o, input logic [31:0] a, b, acc,
                       output logic [31:0] r, output logic [31:0] rm, output logic dz);
    int sa, sb;
    r = 32'h0; rm = 32'h0; dz = 1'b0;
    case (o)
      2'd0: r = a * b;
      2'd1: r = a * b + acc;
      default: begin
        if (b == 32'h0) begin
          rm = a; dz = 1'b1;
        end else if (o == 2'd2) begin
          r = a / b; rm = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = 32'h8000_0000;
        end else begin
          sa = a; sb = b;
          r = sa / sb; rm = sa % sb;
        end
      end
    endcase
  endtask

  // Called at a negedge: request is sampled at the next posedge, inputs then scrambled.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, b, acc);
    op = o; SrcA = a; SrcB = b; SrcAcc = acc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); SrcA = $urandom; SrcB = $urandom; SrcAcc = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] r, rm, input logic dz);
    check({name, " Result"}, Result, r);
    check({name, " Remainder"}, Remainder, rm);
    check({name, " DivZero"}, {31'h0, DivZero}, {31'h0, dz});
  endtask

  logic [31:0] er, erm;
  logic        edz;
  int          lat, bc, pulses;
  logic [1:0]  ro;
  logic [31:0] ra, rb, racc;

  initial begin
    tbl[0]  = '{2'd0, 32'h0001_0003, 32'h0000_0005, 32'h0, 32'h0005_000F, 32'h0, 1'b0};
    tbl[1]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 32'h0, 1'b0};
    tbl[2]  = '{2'd1, 32'd7, 32'd6, 32'hFFFF_FFF0, 32'h0000_001A, 32'h0, 1'b0};
    tbl[3]  = '{2'd2, 32'd100, 32'd7, 32'h0, 32'd14, 32'd2, 1'b0};
    tbl[4]  = '{2'd3, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    tbl[5]  = '{2'd3, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFD, 32'd1, 1'b0};
    tbl[6]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0, 1'b0};
    tbl[7]  = '{2'd2, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 32'h0000_1234, 1'b1};
    tbl[8]  = '{2'd0, 32'd2, 32'd3, 32'h0, 32'd6, 32'h0, 1'b0};
    tbl[9]  = '{2'd3, 32'hFFFF_FF9C, 32'h0, 32'h0, 32'h0, 32'hFFFF_FF9C, 1'b1};
    tbl[10] = '{2'd3, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'h0, 32'd2, 32'hFFFF_FFFE, 1'b0};
    tbl[11] = '{2'd3, 32'h8000_0000, 32'd1, 32'h0, 32'h8000_0000, 32'h0, 1'b0};

    reset = 1'b1; start = 1'b0; op = 2'd0; SrcA = 32'h0; SrcB = 32'h0; SrcAcc = 32'h0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check_out("reset", 32'h0, 32'h0, 1'b0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      launch(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].acc);
      wait_done(lat, bc);
      check($sformatf("tbl%0d latency", i), lat, 32'd33);
      check($sformatf("tbl%0d busy cycles", i), bc, 32'd33);
      check_out($sformatf("tbl%0d", i), tbl[i].res, tbl[i].rem, tbl[i].dz);
      @(negedge clk);
      check($sformatf("tbl%0d done pulse width", i), {31'h0, done}, 32'h0);
      check_out($sformatf("tbl%0d hold", i), tbl[i].res, tbl[i].rem, tbl[i].dz);
    end

    // Back-to-back: second start issued during the DONE cycle.
    @(negedge clk);
    launch(2'd1, 32'd7, 32'd6, 32'hFFFF_FFF0);
    wait_done(lat, bc);
    check_out("b2b first", 32'h0000_001A, 32'h0, 1'b0);
    launch(2'd2, 32'd100, 32'd7, 32'h0);
    check("b2b busy rises", {31'h0, busy}, 32'h1);
    wait_done(lat, bc);
    check("b2b latency", lat, 32'd33);
    check_out("b2b second", 32'd14, 32'd2, 1'b0);

    // Start during RUN is ignored.
    @(negedge clk);
    launch(2'd0, 32'h0000_1234, 32'h0000_0010, 32'h0);
    repeat (5) @(negedge clk);
    op = 2'd2; SrcA = 32'd999; SrcB = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("ignored start latency", lat, 32'd27);
    check_out("ignored start", 32'h0001_2340, 32'h0, 1'b0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ignored start extra done", pulses, 32'd0);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    launch(2'd2, 32'd100, 32'd7, 32'h0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun reset busy", {31'h0, busy}, 32'h0);
    check("midrun reset done", {31'h0, done}, 32'h0);
    check_out("midrun reset", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrun reset no done", pulses, 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 20);
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      racc = $urandom;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      launch(ro, ra, rb, racc);
      wait_done(lat, bc);
      model(ro, ra, rb, racc, er, erm, edz);
      check($sformatf("rnd%0d latency", i), lat, 32'd33);
      check_out($sformatf("rnd%0d op%0d a=%h b=%h", i, ro, ra, rb), er, erm, edz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
